sum_window_accum: RTL and testbench

Downstream consumer of the registered dual-adder stage. Takes its `size`-bit `Dataout` sum stream plus a qualifying valid and accumulates fixed windows of 2**`log2_win` samples. Presents each window total and its truncated average to the next stage through a one-entry valid/ready output register. The upstream stage has no backpressure, so samples are never stalled; window results that arrive while the output register is still occupied are dropped and flagged.

---
 rtl/sum_window_accum.sv | 118 +++++++++++
 tb/tb_sum_window_accum.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_window_accum.sv
// Accumulates fixed windows of 2**log2_win samples and presents each window sum
// and truncated average through a one-entry valid/ready output register.
module sum_window_accum #(
    parameter int unsigned size     = 8,
    parameter int unsigned log2_win = 3
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [size-1:0]              Datain,
    input  logic                         Datain_valid,
    input  logic                         clear,
    output logic [size+log2_win-1:0]     Dataout,
    output logic [size-1:0]              Average,
    output logic                         Dataout_valid,
    input  logic                         Dataout_ready,
    output logic [log2_win-1:0]          Count,
    output logic                         overrun
);

    localparam int unsigned AccW = size + log2_win;

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e                state_q, state_d;
    logic [AccW-1:0]       acc_q, acc_d;
    logic [log2_win-1:0]   count_q, count_d;
    logic [AccW-1:0]       dout_q, dout_d;
    logic [size-1:0]       avg_q, avg_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    logic                  accept;
    logic                  complete;
    logic                  out_free;
    logic [AccW-1:0]       acc_base;
    logic [AccW-1:0]       sum_full;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else if (Datain_valid && (state_q == StIdle)) begin
            state_d = StAccum;
        end
    end

    always_comb begin
        accept    = Datain_valid && !clear;
        // Count is all ones exactly when this sample is the Nth of the window.
        complete  = accept && (&count_q);
        out_free  = !valid_q || Dataout_ready;
        acc_base  = (state_q == StIdle) ? '0 : acc_q;
        sum_full  = acc_base + {{log2_win{1'b0}}, Datain};

        acc_d     = acc_q;
        count_d   = count_q;
        dout_d    = dout_q;
        avg_d     = avg_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (clear) begin
            acc_d   = '0;
            count_d = '0;
        end else if (accept) begin
            acc_d   = complete ? '0 : sum_full;
            count_d = count_q + 1'b1;
        end

        if (valid_q && Dataout_ready) begin
            valid_d = 1'b0;
        end
        if (complete && out_free) begin
            dout_d  = sum_full;
            avg_d   = sum_full[AccW-1:log2_win];
            valid_d = 1'b1;
        end

        if (clear) begin
            overrun_d = 1'b0;
        end else if (complete && !out_free) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc_q     <= '0;
            count_q   <= '0;
            dout_q    <= '0;
            avg_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            count_q   <= count_d;
            dout_q    <= dout_d;
            avg_q     <= avg_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign Dataout       = dout_q;
    assign Average       = avg_q;
    assign Dataout_valid = valid_q;
    assign Count         = count_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_sum_window_accum.sv
// Directed and randomized checks of sum_window_accum against a queue-based window model.
module tb_sum_window_accum;

    localparam int unsigned Size    = 8;
    localparam int unsigned Log2Win = 3;
    localparam int unsigned N       = 1 << Log2Win;

    logic                    Clk = 1'b0;
    logic                    Reset;
    logic [Size-1:0]         Datain;
    logic                    Datain_valid;
    logic                    clear;
    logic [Size+Log2Win-1:0] Dataout;
    logic [Size-1:0]         Average;
    logic                    Dataout_valid;
    logic                    Dataout_ready;
    logic [Log2Win-1:0]      Count;
    logic                    overrun;

    sum_window_accum #(
        .size     (Size),
        .log2_win (Log2Win)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Datain        (Datain),
        .Datain_valid  (Datain_valid),
        .clear         (clear),
        .Dataout       (Dataout),
        .Average       (Average),
        .Dataout_valid (Dataout_valid),
        .Dataout_ready (Dataout_ready),
        .Count         (Count),
        .overrun       (overrun)
    );

    always #5 Clk = ~Clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: the partial window is a plain list of accepted samples.
    int unsigned m_win[$];
    int unsigned m_dout  = 0;
    int unsigned m_avg   = 0;
    bit          m_valid = 1'b0;
    bit          m_over  = 1'b0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input int unsigned din, input bit dv, input bit clr,
                              input bit rdy);
        int unsigned s;
        bit          next_valid;
        if (rst) begin
            m_win.delete();
            m_dout  = 0;
            m_avg   = 0;
            m_valid = 1'b0;
            m_over  = 1'b0;
            return;
        end
        next_valid = m_valid && !rdy;
        if (clr) begin
            m_win.delete();
            m_over = 1'b0;
        end else if (dv) begin
            m_win.push_back(din);
            if (m_win.size() == N) begin
                s = 0;
                foreach (m_win[i]) s += m_win[i];
                m_win.delete();
                if (!m_valid || rdy) begin
                    m_dout     = s;
                    m_avg      = s / N;
                    next_valid = 1'b1;
                end else begin
                    m_over = 1'b1;
                end
            end
        end
        m_valid = next_valid;
    endtask

    task automatic compare_all();
        check("dout",    Dataout,       m_dout);
        check("avg",     Average,       m_avg);
        check("valid",   Dataout_valid, m_valid);
        check("count",   Count,         m_win.size());
        check("overrun", overrun,       m_over);
    endtask

    task automatic step(input bit rst, input int unsigned din, input bit dv, input bit clr,
                        input bit rdy);
        Reset         = rst;
        Datain        = din[Size-1:0];
        Datain_valid  = dv;
        clear         = clr;
        Dataout_ready = rdy;
        @(posedge Clk);
        model_edge(rst, din & 32'hff, dv, clr, rdy);
        #1;
        compare_all();
    endtask

    task automatic send(input int unsigned din, input bit rdy);
        step(1'b0, din, 1'b1, 1'b0, rdy);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        Reset = 1'b1; Datain = '0; Datain_valid = 1'b0; clear = 1'b0; Dataout_ready = 1'b0;
        #1;
        step(1'b1, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 1'b0, 1'b0, 1'b0);
        check("reset_valid", Dataout_valid, 0);
        check("reset_count", Count, 0);

        // Window sum/average with ready held high.
        for (int i = 0; i < 8; i++) begin
            send(10, 1'b1);
            if (i < 7) check("count_step", Count, i + 1);
        end
        check("w10_count", Count, 0);
        check("w10_dout", Dataout, 80);
        check("w10_avg", Average, 10);
        check("w10_valid", Dataout_valid, 1);
        idle(1'b1);
        check("w10_one_cycle", Dataout_valid, 0);

        // Full scale, then 1..8 with random gaps.
        for (int i = 0; i < 8; i++) send(255, 1'b1);
        check("fs_dout", Dataout, 2040);
        check("fs_avg", Average, 255);
        for (int i = 1; i <= 8; i++) begin
            int unsigned gaps = $urandom_range(0, 4);
            for (int g = 0; g < int'(gaps); g++) idle(1'b1);
            send(i, 1'b1);
        end
        check("ramp_dout", Dataout, 36);
        check("ramp_avg", Average, 4);
        idle(1'b1);

        // Backpressure and overrun.
        for (int i = 0; i < 8; i++) send(5, 1'b0);
        for (int i = 0; i < 8; i++) send(7, 1'b0);
        check("bp_dout", Dataout, 40);
        check("bp_overrun", overrun, 1);
        idle(1'b1);
        check("bp_consumed", Dataout_valid, 0);
        check("bp_sticky", overrun, 1);

        // Simultaneous consume and complete.
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send(2, 1'b0);
        for (int i = 0; i < 7; i++) send(4, 1'b0);
        send(4, 1'b1);
        check("sim_dout", Dataout, 32);
        check("sim_valid", Dataout_valid, 1);
        check("sim_overrun", overrun, 0);
        idle(1'b1);

        // Clear wins over a same-edge sample.
        for (int i = 0; i < 3; i++) send(100, 1'b1);
        step(1'b0, 100, 1'b1, 1'b1, 1'b1);
        check("clr_count", Count, 0);
        for (int i = 0; i < 8; i++) send(1, 1'b1);
        check("clr_dout", Dataout, 8);
        idle(1'b1);

        // Reset mid-window with a pending result.
        for (int i = 0; i < 8; i++) send(9, 1'b0);
        for (int i = 0; i < 5; i++) send(6, 1'b0);
        step(1'b1, 6, 1'b1, 1'b0, 1'b0);
        check("rst_dout", Dataout, 0);
        check("rst_avg", Average, 0);
        check("rst_valid", Dataout_valid, 0);
        check("rst_count", Count, 0);
        check("rst_overrun", overrun, 0);
        for (int i = 0; i < 8; i++) send(3, 1'b1);
        check("rst_after_dout", Dataout, 24);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bit rst = ($urandom_range(0, 299) == 0);
            bit clr = ($urandom_range(0, 39) == 0);
            bit dv  = ($urandom_range(0, 3) != 0);
            bit rdy = ($urandom_range(0, 2) != 0);
            step(rst, $urandom_range(0, 255), dv, clr, rdy);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
